// File: rtl/stack_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stack_ctrl_if: ALU-side and stackram-side signals of stack_ctrl        |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
interface stack_ctrl_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);
  logic [1:0]        op;
  logic [WIDTH-1:0]  din;
  logic [WIDTH-1:0]  tos;
  logic [WIDTH-1:0]  nos;
  logic [WIDTH-1:0]  ram_data;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_wraddr;
  logic [ADDR_W-1:0] ram_rdaddr;
  logic [WIDTH-1:0]  ram_q;
  logic              clr_err;
  logic              ovf;
  logic              unf;

  modport master (
    output op, din, clr_err, ram_q,
    input  tos, nos, ram_data, ram_wren, ram_wraddr, ram_rdaddr, ovf, unf
  );

  modport slave (
    input  op, din, clr_err, ram_q,
    output tos, nos, ram_data, ram_wren, ram_wraddr, ram_rdaddr, ovf, unf
  );
endinterface
`default_nettype wire

// File: rtl/stack_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stack_ctrl: stack pointer + T register in front of an 8-entry stackram|
// | Optional depth/overflow checking: STACK_DEPTH_CHECK_EN. Rev 1.0       |
// +----------------------------------------------------------------------+
module stack_ctrl #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic         clock,
  input  logic         reset,
  stack_ctrl_if.slave  bus
);
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;
  localparam int         DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] SP_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [WIDTH-1:0]  t_q, t_d;
  logic              fwd_valid_q, fwd_valid_d;
  logic [WIDTH-1:0]  fwd_data_q, fwd_data_d;
  logic [WIDTH-1:0]  nos;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_wraddr;
  logic [WIDTH-1:0]  ram_data;

  // The RAM returns old data when the read address was written at the same
  // edge, so the freshly pushed N is served from the bypass register instead.
  assign nos = fwd_valid_q ? fwd_data_q : bus.ram_q;

  always_comb begin
    sp_d        = sp_q;
    t_d         = t_q;
    fwd_valid_d = fwd_valid_q;
    fwd_data_d  = fwd_data_q;
    ram_wren    = 1'b0;
    ram_wraddr  = sp_q + SP_ONE;
    ram_data    = t_q;
    if (reset) begin
      sp_d        = '0;
      t_d         = '0;
      fwd_valid_d = 1'b1;
      fwd_data_d  = '0;
    end else begin
      case (bus.op)
        OP_PUSH: begin
          ram_wren    = 1'b1;
          sp_d        = sp_q + SP_ONE;
          t_d         = bus.din;
          fwd_valid_d = 1'b1;
          fwd_data_d  = t_q;
        end
        OP_POP: begin
          sp_d        = sp_q - SP_ONE;
          t_d         = nos;
          fwd_valid_d = 1'b0;
        end
        OP_REPL: t_d = bus.din;
        OP_NOP:  ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sp_q        <= '0;
      t_q         <= '0;
      fwd_valid_q <= 1'b1;
      fwd_data_q  <= '0;
    end else begin
      sp_q        <= sp_d;
      t_q         <= t_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign bus.tos        = t_q;
  assign bus.nos        = nos;
  assign bus.ram_wren   = ram_wren;
  assign bus.ram_wraddr = ram_wraddr;
  assign bus.ram_data   = ram_data;
  // Read address tracks the next sp so ram_q lines up with it one cycle later.
  assign bus.ram_rdaddr = sp_d;

`ifdef STACK_DEPTH_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_ONE  = (ADDR_W+1)'(1);

  logic [ADDR_W:0] depth_q, depth_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            ovf_evt, unf_evt;

  always_comb begin
    depth_d = depth_q;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (bus.op == OP_PUSH) begin
      if (depth_q == DEPTH_FULL) ovf_evt = 1'b1;
      else                       depth_d = depth_q + DEPTH_ONE;
    end else if (bus.op == OP_POP) begin
      if (depth_q == '0) unf_evt = 1'b1;
      else               depth_d = depth_q - DEPTH_ONE;
    end
    // A new error event outranks a simultaneous clear.
    ovf_d = ovf_evt | (ovf_q & ~bus.clr_err);
    unf_d = unf_evt | (unf_q & ~bus.clr_err);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.unf = unf_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = bus.clr_err;
  assign bus.ovf        = 1'b0;
  assign bus.unf        = 1'b0;
`endif
endmodule
`default_nettype wire
